excp_ctrl: RTL and testbench

- Exception/interrupt sequencer in front of the CP0 register file.
- Evaluates pending interrupts against Status mask and enable bits, and arbitrates interrupt, syscall and eret for the committing instruction.
- Drives a one-cycle excptype and exception PC into CP0, then flushes the pipeline and issues a PC redirect to the handler or to EPC.

---
 rtl/excp_ctrl_pkg.sv | 41 ++++
 rtl/excp_prio_enc.sv | 49 ++++
 rtl/excp_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_excp_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/excp_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// excp_ctrl_pkg
// Shared definitions for the exception/interrupt sequencer:
//   - excptype codes driven into CP0
//   - CP0 Status bit positions (IE, EXL, IM)
//   - sequencer FSM state encoding
//   - default handler entry address
// -----------------------------------------------------------------------------
package excp_ctrl_pkg;

    // Exception codes presented to CP0 for one cycle
    localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
    localparam logic [31:0] EXC_INT     = 32'h0000_0004;
    localparam logic [31:0] EXC_SYSCALL = 32'h0000_0100;
    localparam logic [31:0] EXC_ERET    = 32'h0000_0200;

    // CP0 Status bit indices
    localparam int STATUS_IE     = 0;
    localparam int STATUS_EXL    = 1;
    localparam int STATUS_IM_LSB = 10;
    localparam int STATUS_IM_MSB = 15;

    // Default exception/interrupt handler entry PC
    localparam logic [31:0] DEFAULT_HANDLER_ADDR = 32'h0000_0040;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_TRAP     = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_REDIRECT = 2'd3
    } state_t;

    // Flush duration clamp: 0 behaves as 1, values above 15 saturate
    function automatic logic [3:0] flush_load(input int cycles);
        int eff;
        eff = (cycles < 1) ? 1 : ((cycles > 15) ? 15 : cycles);
        return 4'(eff - 1);
    endfunction

endpackage

// File: rtl/excp_prio_enc.sv
// -----------------------------------------------------------------------------
// excp_prio_enc
// Combinational mask-and-priority encoder. Qualifies pending interrupt lines
// with Status IE/EXL/IM, then selects interrupt > syscall > eret for the
// committing instruction.
// Ports:
//   inst_valid_i  commit-stage instruction valid
//   cause_ip_i    pending interrupt lines (already synchronised if enabled)
//   ie_i, exl_i   Status.IE and Status.EXL
//   im_i          Status.IM[7:2] (bits 15:10)
//   is_syscall_i  commit instruction is SYSCALL
//   is_eret_i     commit instruction is ERET
//   code_o        winning excptype code (EXC_NONE when nothing wins)
//   valid_o       an event wins this cycle
// -----------------------------------------------------------------------------
module excp_prio_enc
    import excp_ctrl_pkg::*;
(
    input  logic        inst_valid_i,
    input  logic [5:0]  cause_ip_i,
    input  logic        ie_i,
    input  logic        exl_i,
    input  logic [5:0]  im_i,
    input  logic        is_syscall_i,
    input  logic        is_eret_i,
    output logic [31:0] code_o,
    output logic        valid_o
);

    logic int_req;

    assign int_req = inst_valid_i & ie_i & ~exl_i & (|(cause_ip_i & im_i));

    always_comb begin
        code_o  = EXC_NONE;
        valid_o = 1'b0;
        if (int_req) begin
            code_o  = EXC_INT;
            valid_o = 1'b1;
        end else if (inst_valid_i && is_syscall_i) begin
            code_o  = EXC_SYSCALL;
            valid_o = 1'b1;
        end else if (inst_valid_i && is_eret_i) begin
            code_o  = EXC_ERET;
            valid_o = 1'b1;
        end
    end

endmodule

// File: rtl/excp_ctrl.sv
// -----------------------------------------------------------------------------
// excp_ctrl
// Exception/interrupt sequencer in front of the CP0 register file. For each
// accepted event it presents excptype/excp_pc to CP0 for one cycle, holds the
// pipeline flushed for FLUSH_CYCLES cycles, then issues a one-cycle PC
// redirect to HANDLER_ADDR (or to EPC for ERET). All outputs are registered.
//
// Optional build macro:
//   INTR_SYNC_EN  cause_ip passes through a 2-flop synchroniser before
//                 interrupt evaluation (+2 cycles of detection latency).
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   cause_ip         pending interrupt lines (Cause[15:10])
//   status           CP0 Status ([0]=IE, [1]=EXL, [15:10]=IM)
//   epc              CP0 EPC readback
//   inst_valid       commit-stage instruction valid
//   inst_pc          commit-stage PC
//   is_syscall       commit instruction is SYSCALL
//   is_eret          commit instruction is ERET
//   excptype         exception code to CP0 (nonzero for exactly one cycle)
//   excp_pc          PC to CP0 for EPC, held through the whole sequence
//   flush            pipeline flush
//   stall            freeze fetch/commit
//   redirect_valid   one-cycle PC redirect strobe
//   redirect_pc      redirect target
// -----------------------------------------------------------------------------
module excp_ctrl
    import excp_ctrl_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = DEFAULT_HANDLER_ADDR,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  cause_ip,
    input  logic [31:0] status,
    input  logic [31:0] epc,
    input  logic        inst_valid,
    input  logic [31:0] inst_pc,
    input  logic        is_syscall,
    input  logic        is_eret,
    output logic [31:0] excptype,
    output logic [31:0] excp_pc,
    output logic        flush,
    output logic        stall,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    localparam logic [3:0] CNT_LOAD = flush_load(FLUSH_CYCLES);

    // ---------------------------------------------------------------------
    // Interrupt line conditioning
    // ---------------------------------------------------------------------
    logic [5:0] cause_eff;

`ifdef INTR_SYNC_EN
    logic [5:0] cause_s1_q;
    logic [5:0] cause_s2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cause_s1_q <= '0;
            cause_s2_q <= '0;
        end else begin
            cause_s1_q <= cause_ip;
            cause_s2_q <= cause_s1_q;
        end
    end

    assign cause_eff = cause_s2_q;
`else
    assign cause_eff = cause_ip;
`endif

    // Only IE, EXL and IM matter here; the rest of Status is ignored.
    logic unused_status;
    assign unused_status = ^{status[31:STATUS_IM_MSB+1], status[STATUS_IM_LSB-1:STATUS_EXL+1]};

    // ---------------------------------------------------------------------
    // Event selection
    // ---------------------------------------------------------------------
    logic [31:0] evt_code;
    logic        evt_valid;

    excp_prio_enc u_prio (
        .inst_valid_i (inst_valid),
        .cause_ip_i   (cause_eff),
        .ie_i         (status[STATUS_IE]),
        .exl_i        (status[STATUS_EXL]),
        .im_i         (status[STATUS_IM_MSB:STATUS_IM_LSB]),
        .is_syscall_i (is_syscall),
        .is_eret_i    (is_eret),
        .code_o       (evt_code),
        .valid_o      (evt_valid)
    );

    // ---------------------------------------------------------------------
    // Sequencer
    // ---------------------------------------------------------------------
    state_t      state_q;
    logic [31:0] code_q;            // latched code, kept after excptype clears
    logic [3:0]  cnt_q;
    logic [31:0] excptype_q;
    logic [31:0] excp_pc_q;
    logic        flush_q;
    logic        stall_q;
    logic        redirect_valid_q;
    logic [31:0] redirect_pc_q;
    logic [31:0] redirect_pc_d;

    // EPC is sampled on the edge entering REDIRECT; CP0 has written it during
    // the TRAP cycle, so it is already current by then.
    always_comb begin
        redirect_pc_d = HANDLER_ADDR;
        if (code_q == EXC_ERET) begin
            redirect_pc_d = epc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            code_q           <= EXC_NONE;
            cnt_q            <= '0;
            excptype_q       <= EXC_NONE;
            excp_pc_q        <= '0;
            flush_q          <= 1'b0;
            stall_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (evt_valid) begin
                        state_q    <= ST_TRAP;
                        code_q     <= evt_code;
                        cnt_q      <= CNT_LOAD;
                        excptype_q <= evt_code;
                        excp_pc_q  <= inst_pc;
                        flush_q    <= 1'b1;
                        stall_q    <= 1'b1;
                    end
                end

                ST_TRAP: begin
                    excptype_q <= EXC_NONE;
                    if (cnt_q != 4'd0) begin
                        state_q <= ST_FLUSH;
                        cnt_q   <= cnt_q - 4'd1;
                    end else begin
                        state_q          <= ST_REDIRECT;
                        flush_q          <= 1'b0;
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= redirect_pc_d;
                    end
                end

                ST_FLUSH: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q          <= ST_REDIRECT;
                        flush_q          <= 1'b0;
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= redirect_pc_d;
                    end
                end

                ST_REDIRECT: begin
                    state_q          <= ST_IDLE;
                    code_q           <= EXC_NONE;
                    excp_pc_q        <= '0;
                    stall_q          <= 1'b0;
                    redirect_valid_q <= 1'b0;
                    redirect_pc_q    <= '0;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign excptype       = excptype_q;
    assign excp_pc        = excp_pc_q;
    assign flush          = flush_q;
    assign stall          = stall_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_excp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_excp_ctrl
// Directed steps followed by a randomized run. A behavioural reference model
// tracks the position of the current event within its FLUSH_CYCLES+1 cycle
// window and derives every expected output from that position.
// -----------------------------------------------------------------------------
module tb_excp_ctrl;

    localparam int          TB_FC   = 2;
    localparam logic [31:0] HANDLER = 32'h0000_0040;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  cause_ip;
    logic [31:0] status;
    logic [31:0] epc;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic        is_syscall;
    logic        is_eret;
    logic [31:0] excptype;
    logic [31:0] excp_pc;
    logic        flush;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    excp_ctrl #(
        .HANDLER_ADDR (HANDLER),
        .FLUSH_CYCLES (TB_FC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cause_ip       (cause_ip),
        .status         (status),
        .epc            (epc),
        .inst_valid     (inst_valid),
        .inst_pc        (inst_pc),
        .is_syscall     (is_syscall),
        .is_eret        (is_eret),
        .excptype       (excptype),
        .excp_pc        (excp_pc),
        .flush          (flush),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: phase < 0 means idle, otherwise cycles since acceptance
    int          m_phase = -1;
    logic [31:0] m_code  = 32'h0;
    logic [31:0] m_pc    = 32'h0;
    logic [31:0] m_rpc   = 32'h0;
    logic [5:0]  m_s1    = 6'h0;
    logic [5:0]  m_s2    = 6'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // One clock: update the model with the inputs seen at the edge, then
    // compare every output 1 time unit later.
    task automatic tick();
        logic [5:0]  c_eff;
        logic        int_req;
        logic [31:0] e_type, e_pc, e_rpc;
        logic        e_fl, e_st, e_rv;
        @(posedge clk);
        cyc++;
`ifdef INTR_SYNC_EN
        c_eff = m_s2;
`else
        c_eff = cause_ip;
`endif
        m_s2 = rst ? 6'h0 : m_s1;
        m_s1 = rst ? 6'h0 : cause_ip;
        int_req = inst_valid && status[0] && !status[1] && ((c_eff & status[15:10]) != 6'h0);
        if (rst) begin
            m_phase = -1;
        end else if (m_phase < 0) begin
            if (int_req || (inst_valid && (is_syscall || is_eret))) begin
                m_phase = 0;
                m_code  = int_req ? 32'h4 : (is_syscall ? 32'h100 : 32'h200);
                m_pc    = inst_pc;
            end
        end else begin
            m_phase++;
            if (m_phase == TB_FC) m_rpc = (m_code == 32'h200) ? epc : HANDLER;
            if (m_phase > TB_FC) m_phase = -1;
        end
        #1;
        e_type = (m_phase == 0) ? m_code : 32'h0;
        e_pc   = (m_phase >= 0) ? m_pc : 32'h0;
        e_fl   = (m_phase >= 0) && (m_phase < TB_FC);
        e_st   = (m_phase >= 0);
        e_rv   = (m_phase == TB_FC);
        e_rpc  = e_rv ? m_rpc : 32'h0;
        chk("excptype", excptype, e_type);
        chk("excp_pc", excp_pc, e_pc);
        chk("flush", {31'h0, flush}, {31'h0, e_fl});
        chk("stall", {31'h0, stall}, {31'h0, e_st});
        chk("redirect_valid", {31'h0, redirect_valid}, {31'h0, e_rv});
        chk("redirect_pc", redirect_pc, e_rpc);
        $display("[TB] cyc=%0d rst=%b v=%b sys=%b eret=%b ip=%h st=%h | type=%h pc=%h fl=%b stl=%b rv=%b rpc=%h",
                 cyc, rst, inst_valid, is_syscall, is_eret, cause_ip, status,
                 excptype, excp_pc, flush, stall, redirect_valid, redirect_pc);
    endtask

    int cnt_nz;
    int cnt_rv;
    int sel;

    initial begin
        // Reset with a pending, enabled interrupt
        rst = 1'b1; status = 32'h0000_FC01; cause_ip = 6'h01; inst_valid = 1'b1;
        inst_pc = 32'h0000_1000; epc = 32'h0; is_syscall = 1'b0; is_eret = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_then_int", excptype, 32'h4);
        cause_ip = 6'h00;
        repeat (4) tick();

        // Syscall
        inst_pc = 32'h0000_0100; is_syscall = 1'b1;
        tick();
        is_syscall = 1'b0;
        repeat (4) tick();

        // ERET while EXL=1 with an interrupt pending; CP0 clears EXL afterwards
        status = 32'h0000_FC03; cause_ip = 6'h01;
        repeat (3) tick();
        epc = 32'h0000_0204; is_eret = 1'b1; inst_pc = 32'h0000_0300;
        tick();
        is_eret = 1'b0; status = 32'h0000_FC01;
        repeat (6) tick();
        cause_ip = 6'h00;
        repeat (4) tick();

        // Masking: EXL=1, IM=0, IE=0
        cnt_nz = 0;
        cause_ip = 6'h3F;
        for (int k = 0; k < 3; k++) begin
            status = (k == 0) ? 32'h0000_FC03 : ((k == 1) ? 32'h0000_0001 : 32'h0000_FC00);
            repeat (20) begin
                tick();
                if (excptype != 32'h0) cnt_nz++;
            end
        end
        chk("mask_none", cnt_nz, 0);

        // All three events at once, syscall held into the flush window
        status = 32'h0000_FC01; cause_ip = 6'h01; is_syscall = 1'b1; is_eret = 1'b1;
        inst_pc = 32'h0000_0500;
        tick();
        chk("prio_int", excptype, 32'h4);
        cause_ip = 6'h00; is_eret = 1'b0;
        repeat (2) tick();
        is_syscall = 1'b0;
        repeat (4) tick();

        // Reset during FLUSH: no redirect may follow
        cnt_rv = 0;
        is_syscall = 1'b1; inst_pc = 32'h0000_0600;
        tick();
        is_syscall = 1'b0;
        tick();
        if (redirect_valid) cnt_rv++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (4) begin
            tick();
            if (redirect_valid) cnt_rv++;
        end
        chk("rst_no_redirect", cnt_rv, 0);

        // Randomized run
        repeat (600) begin
            rst        = ($urandom_range(0, 49) == 0);
            inst_valid = ($urandom_range(0, 3) != 0);
            is_syscall = ($urandom_range(0, 9) == 0);
            is_eret    = ($urandom_range(0, 9) == 0);
            cause_ip   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h00;
            sel = $urandom_range(0, 4);
            case (sel)
                0: status = 32'h0000_FC01;
                1: status = 32'h0000_FC03;
                2: status = 32'h0000_0001;
                3: status = 32'h0000_FC00;
                default: status = $urandom;
            endcase
            inst_pc = $urandom;
            epc     = $urandom;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
